// File: rtl/tdc_thermo_encoder.sv
// Captures the delay-line thermometer code, detects tap-0 rising edges and emits
// a bubble-tolerant popcount fine time with the matching coarse count on valid/ready.
module tdc_thermo_encoder #(
    parameter int  NUM_ELEMENTS = 32,
    parameter int  COARSE_WIDTH = 16,
    localparam int FINE_WIDTH   = $clog2(NUM_ELEMENTS + 2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_ELEMENTS:0]   delay_value,
    input  logic                    enable,
    output logic                    ts_valid,
    input  logic                    ts_ready,
    output logic [FINE_WIDTH-1:0]   ts_fine,
    output logic [COARSE_WIDTH-1:0] ts_coarse,
    output logic                    missed
);

    localparam int TAPS        = NUM_ELEMENTS + 1;
    localparam int NUM_GROUPS  = (TAPS + 7) / 8;
    localparam int PAD_WIDTH   = NUM_GROUPS * 8;
    localparam int GROUP_WIDTH = 4;

    typedef enum logic [1:0] {IDLE, ARMED, BUSY, VALID} state_t;

    state_t state, state_next;

    logic [TAPS-1:0]         s1, s2;
    logic                    s2_prev0;
    logic                    tap_edge;
    logic [COARSE_WIDTH-1:0] coarse_cnt, coarse_d1, coarse_d2, enc_coarse;
    logic [PAD_WIDTH-1:0]    s2_pad;
    logic [GROUP_WIDTH-1:0]  group_sum [NUM_GROUPS];
    logic [GROUP_WIDTH-1:0]  group_q   [NUM_GROUPS];
    logic [FINE_WIDTH-1:0]   fine_sum;
    logic                    launch, load;

    // The coarse count is delayed alongside s1/s2 so it refers to the s1 sample cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            s2_prev0   <= 1'b0;
            coarse_cnt <= '0;
            coarse_d1  <= '0;
            coarse_d2  <= '0;
        end else begin
            s1         <= delay_value;
            s2         <= s1;
            s2_prev0   <= s2[0];
            coarse_cnt <= coarse_cnt + 1'b1;
            coarse_d1  <= coarse_cnt;
            coarse_d2  <= coarse_d1;
        end
    end

    assign tap_edge = s2[0] & ~s2_prev0;
    assign s2_pad   = PAD_WIDTH'(s2);

    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            group_sum[g] = '0;
            for (int b = 0; b < 8; b++) begin
                group_sum[g] = group_sum[g] + GROUP_WIDTH'(s2_pad[g*8 + b]);
            end
        end
    end

    always_comb begin
        fine_sum = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            fine_sum = fine_sum + FINE_WIDTH'(group_q[g]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                group_q[g] <= '0;
            end
            enc_coarse <= '0;
            ts_fine    <= '0;
            ts_coarse  <= '0;
        end else begin
            if (launch) begin
                group_q    <= group_sum;
                enc_coarse <= coarse_d2;
            end
            if (load) begin
                ts_fine   <= fine_sum;
                ts_coarse <= enc_coarse;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = ARMED;
            ARMED:   if (tap_edge) state_next = BUSY;
            BUSY:    state_next = VALID;
            VALID:   if (ts_ready) state_next = ARMED;
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        ts_valid = (state == VALID);
        launch   = (state == ARMED) && enable && tap_edge;
        load     = (state == BUSY) && enable;
    end

    // Edges seen while a result is in flight or waiting (including the handshake cycle) are lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            missed <= 1'b0;
        end else if (state == IDLE) begin
            missed <= 1'b0;
        end else if (enable && tap_edge && (state == BUSY || state == VALID)) begin
            missed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// Scoreboard bench for tdc_thermo_encoder: expected timestamps are queued when an
// edge is driven and compared when the DUT hands a result over.
module tb_tdc_thermo_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] delay_value;
    logic        enable;
    logic        ts_valid;
    logic        ts_ready;
    logic [5:0]  ts_fine;
    logic [15:0] ts_coarse;
    logic        missed;

    typedef struct packed {
        logic [5:0]  fine;
        logic [15:0] coarse;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_xfer   = 0;
    int          n_valid_cyc = 0;
    logic [15:0] tb_cnt;
    logic        hold_prev = 1'b0;
    logic [5:0]  held_fine;
    logic [15:0] held_coarse;

    tdc_thermo_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .delay_value (delay_value),
        .enable      (enable),
        .ts_valid    (ts_valid),
        .ts_ready    (ts_ready),
        .ts_fine     (ts_fine),
        .ts_coarse   (ts_coarse),
        .missed      (missed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) tb_cnt <= 16'd0;
        else       tb_cnt <= tb_cnt + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new tap word at the current negedge; queue its timestamp if it should be accepted.
    task automatic send(input logic [32:0] word, input bit expect_result);
        exp_t e;
        delay_value = word;
        if (expect_result) begin
            e.fine   = 6'($countones(word));
            e.coarse = tb_cnt;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset) begin
            if (ts_valid) n_valid_cyc++;
            if (ts_valid && hold_prev) begin
                chk("hold_fine", 32'(ts_fine), 32'(held_fine));
                chk("hold_coarse", 32'(ts_coarse), 32'(held_coarse));
            end
            if (ts_valid && ts_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_fine", 32'(ts_fine), 32'(e.fine));
                    chk("xfer_coarse", 32'(ts_coarse), 32'(e.coarse));
                end
            end
            hold_prev   = ts_valid && !ts_ready;
            held_fine   = ts_fine;
            held_coarse = ts_coarse;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        int x0;
        int v0;
        int budget;

        reset       = 1'b1;
        enable      = 1'b0;
        ts_ready    = 1'b0;
        delay_value = '0;
        tick(3);
        chk("rst_valid", 32'(ts_valid), 32'd0);
        chk("rst_fine", 32'(ts_fine), 32'd0);
        chk("rst_coarse", 32'(ts_coarse), 32'd0);
        chk("rst_missed", 32'(missed), 32'd0);
        reset = 1'b0;

        // Clean edge with latency check
        enable   = 1'b1;
        ts_ready = 1'b1;
        tick(4);
        x0 = n_xfer;
        send(33'h0_0000_00FF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("lat_early", 32'(ts_valid), 32'd0);
        end
        tick(1);
        chk("lat_valid", 32'(ts_valid), 32'd1);
        tick(1);
        chk("lat_drop", 32'(ts_valid), 32'd0);
        tick(4);
        chk("clean_count", 32'(n_xfer - x0), 32'd1);
        delay_value = '0;
        tick(4);

        // Bubble and saturated line
        x0 = n_xfer;
        send(33'h0_0000_00F7, 1'b1);
        tick(6);
        delay_value = '0;
        tick(4);
        send(33'h1_FFFF_FFFF, 1'b1);
        tick(6);
        delay_value = '0;
        tick(4);
        chk("bub_sat_count", 32'(n_xfer - x0), 32'd2);
        chk("missed_quiet", 32'(missed), 32'd0);

        // Backpressure with a second edge lost while VALID
        ts_ready = 1'b0;
        x0 = n_xfer;
        send(33'h0_0000_FFFF, 1'b1);
        tick(2);
        delay_value = '0;
        tick(2);
        send(33'h0_0000_0003, 1'b0);
        tick(4);
        chk("bp_missed", 32'(missed), 32'd1);
        chk("bp_no_xfer", 32'(n_xfer - x0), 32'd0);
        ts_ready = 1'b1;
        tick(4);
        chk("bp_one_xfer", 32'(n_xfer - x0), 32'd1);
        chk("bp_missed_sticky", 32'(missed), 32'd1);
        delay_value = '0;
        tick(3);

        // Abort in BUSY
        v0 = n_valid_cyc;
        send(33'h0_0000_00FF, 1'b0);
        tick(3);
        enable = 1'b0;
        tick(3);
        chk("abort_no_valid", 32'(n_valid_cyc - v0), 32'd0);
        chk("abort_missed_clr", 32'(missed), 32'd0);
        delay_value = '0;
        enable = 1'b1;
        tick(3);

        // Reset while VALID
        ts_ready = 1'b0;
        send(33'h0_0000_000F, 1'b0);
        budget = 10;
        while (!ts_valid && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("rv_reached_valid", 32'(ts_valid), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("rv_valid", 32'(ts_valid), 32'd0);
        chk("rv_fine", 32'(ts_fine), 32'd0);
        chk("rv_coarse", 32'(ts_coarse), 32'd0);
        chk("rv_missed", 32'(missed), 32'd0);
        reset       = 1'b0;
        delay_value = '0;
        ts_ready    = 1'b1;
        tick(3);

        // Coarse wrap: edges sampled at 0xFFFF and 0x0002
        budget = 70000;
        while (tb_cnt != 16'hFFFF && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) chk("wrap_wait_timeout", 32'd0, 32'd1);
        x0 = n_xfer;
        delay_value = 33'h0_0000_00FF;
        exp_q.push_back('{fine: 6'd8, coarse: 16'hFFFF});
        tick(1);
        delay_value = '0;
        tick(2);
        delay_value = 33'h0_0000_00FF;
        exp_q.push_back('{fine: 6'd8, coarse: 16'h0002});
        tick(8);
        delay_value = '0;
        chk("wrap_count", 32'(n_xfer - x0), 32'd2);

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
